// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with flush-to-zero and a valid/ready handshake.
// Define FPM_RNE_ROUND_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic [3:0]               out_flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'(2 ** EXP_W - 1);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;

  // Stage 1: unpack, classify, significand product
  logic                 a_sign, b_sign;
  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_frac, b_frac;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic                 s1_nan_d, s1_inf_d, s1_zero_d;
  logic [PW-1:0]        s1_prod_d;
  logic signed [EW-1:0] s1_exp_d;

  always_comb begin
    a_sign    = in_a[W-1];
    b_sign    = in_b[W-1];
    a_exp     = in_a[W-2:MAN_W];
    b_exp     = in_b[W-2:MAN_W];
    a_frac    = in_a[MAN_W-1:0];
    b_frac    = in_b[MAN_W-1:0];
    a_zero    = (a_exp == '0);
    b_zero    = (b_exp == '0);
    a_inf     = (&a_exp) && !(|a_frac);
    b_inf     = (&b_exp) && !(|b_frac);
    a_nan     = (&a_exp) && (|a_frac);
    b_nan     = (&b_exp) && (|b_frac);
    s1_nan_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    s1_inf_d  = (a_inf || b_inf) && !s1_nan_d;
    s1_zero_d = (a_zero || b_zero) && !s1_nan_d && !s1_inf_d;
    s1_prod_d = PW'({1'b1, a_frac}) * PW'({1'b1, b_frac});
    s1_exp_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
  end

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [PW-1:0]        s1_prod;
  logic signed [EW-1:0] s1_exp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_prod  <= '0;
      s1_exp   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= a_sign ^ b_sign;
      s1_nan   <= s1_nan_d;
      s1_inf   <= s1_inf_d;
      s1_zero  <= s1_zero_d;
      s1_prod  <= s1_prod_d;
      s1_exp   <= s1_exp_d;
    end
  end

  // Stage 2: normalise so the leading one sits just above the kept fraction
  logic                 msb;
  logic [MAN_W-1:0]     s2_frac_d;
  logic                 s2_guard_d, s2_sticky_d;
  logic signed [EW-1:0] exp_inc;
  logic signed [EW-1:0] s2_exp_d;

  always_comb begin
    msb         = s1_prod[PW-1];
    s2_frac_d   = msb ? s1_prod[PW-2:MAN_W+1] : s1_prod[PW-3:MAN_W];
    s2_guard_d  = msb ? s1_prod[MAN_W] : s1_prod[MAN_W-1];
    s2_sticky_d = msb ? (|s1_prod[MAN_W-1:0]) : (|s1_prod[MAN_W-2:0]);
    exp_inc     = {{(EW-1){1'b0}}, msb};
    s2_exp_d    = s1_exp + exp_inc;
  end

  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [MAN_W-1:0]     s2_frac;
  logic                 s2_guard, s2_sticky;
  logic signed [EW-1:0] s2_exp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_frac   <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
      s2_exp    <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_frac   <= s2_frac_d;
      s2_guard  <= s2_guard_d;
      s2_sticky <= s2_sticky_d;
      s2_exp    <= s2_exp_d;
    end
  end

  // Stage 3: round, range-check, pack
  logic                 round_inc;
  logic [MAN_W:0]       rnd;
  logic signed [EW-1:0] carry_inc;
  logic signed [EW-1:0] exp_r;
  logic                 inexact;
  logic [W-1:0]         data_d;
  logic [3:0]           flags_d;

  always_comb begin
`ifdef FPM_RNE_ROUND_EN
    round_inc = s2_guard && (s2_sticky || s2_frac[0]);
`else
    round_inc = 1'b0;
`endif
    rnd       = {1'b0, s2_frac} + {{MAN_W{1'b0}}, round_inc};
    carry_inc = {{(EW-1){1'b0}}, rnd[MAN_W]};
    exp_r     = s2_exp + carry_inc;
    inexact   = s2_guard || s2_sticky;
    data_d    = {s2_sign, exp_r[EXP_W-1:0], rnd[MAN_W-1:0]};
    flags_d   = {3'b000, inexact};
    if (s2_nan) begin
      data_d  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = 4'b1000;
    end else if (s2_inf) begin
      data_d  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (s2_zero) begin
      data_d  = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (exp_r >= EMAX) begin
      data_d  = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      data_d  = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      out_data  <= data_d;
      out_flags <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe at EXP_W=8, MAN_W=23: directed IEEE cases, stall and reset.
module tb_fp_mul_pipe;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];

`ifdef FPM_RNE_ROUND_EN
  localparam bit Rne = 1'b1;
`else
  localparam bit Rne = 1'b0;
`endif

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_flags(out_flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Called at a falling edge: samples both handshakes, then advances one cycle.
  task automatic cycle(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) obs_q.push_back({out_flags, out_data});
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [35:0] expv);
    bit acc;
    int n;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    exp_q.push_back(expv);
    n = 0;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: operand %h x %h not accepted within 20 cycles", a, b);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 40) begin
      cycle(acc);
      n++;
    end
  endtask

  task automatic test_reset();
    bit acc;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_flags !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h flags=%b, required 0 0 0 0",
               out_valid, in_ready, out_data, out_flags);
    end
    @(negedge clock);
    cycle(acc);
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    bit acc;
    int lat;
    logic [35:0] e, o;
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle(acc);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_latency: result after %0d cycles, required 3", lat);
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL basic_result: no result, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL basic_result: got flags/data %h, required %h", o, e);
        end
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va[12];
    logic [31:0] vb[12];
    logic [35:0] ve[12];
    logic [35:0] e, o;
    int idx;
    va[0]  = 32'h7F800000; vb[0]  = 32'h00000000; ve[0]  = {4'b1000, 32'h7FC00000};
    va[1]  = 32'hFF800000; vb[1]  = 32'h40000000; ve[1]  = {4'b0000, 32'hFF800000};
    va[2]  = 32'h7F000000; vb[2]  = 32'h7F000000; ve[2]  = {4'b0101, 32'h7F800000};
    va[3]  = 32'h00800000; vb[3]  = 32'h00800000; ve[3]  = {4'b0011, 32'h00000000};
    va[4]  = 32'h3FC00001; vb[4]  = 32'h3FC00001;
    ve[4]  = {4'b0001, (Rne ? 32'h40100002 : 32'h40100001)};
    va[5]  = 32'h7FC12345; vb[5]  = 32'h3F800000; ve[5]  = {4'b1000, 32'h7FC00000};
    va[6]  = 32'h80000000; vb[6]  = 32'h40000000; ve[6]  = {4'b0000, 32'h80000000};
    va[7]  = 32'h00400000; vb[7]  = 32'hC0000000; ve[7]  = {4'b0000, 32'h80000000};
    va[8]  = 32'hC0000000; vb[8]  = 32'h40400000; ve[8]  = {4'b0000, 32'hC0C00000};
    va[9]  = 32'h3FFFFFFE; vb[9]  = 32'h3F800001;
    ve[9]  = {4'b0001, (Rne ? 32'h40000000 : 32'h3FFFFFFF)};
    va[10] = 32'h00000000; vb[10] = 32'hFF800000; ve[10] = {4'b1000, 32'h7FC00000};
    va[11] = 32'h40400000; vb[11] = 32'h40400000; ve[11] = {4'b0000, 32'h41100000};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(va[i], vb[i], ve[i]);
    drain();
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL special_%0d: no result, required %h", idx, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL special_%0d: %h x %h got %h, required %h", idx, va[idx], vb[idx], o, e);
        end
      end
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int n;
    logic [31:0] held;
    logic [35:0] e, o;
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
    send(32'hC0000000, 32'h40400000, {4'b0000, 32'hC0C00000});
    send(32'h40400000, 32'h40400000, {4'b0000, 32'h41100000});
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_valid: out_valid=%b, required 1", out_valid);
    end
    out_ready = 1'b0;
    in_a      = 32'h7F000000;
    in_b      = 32'h7F000000;
    in_valid  = 1'b1;
    exp_q.push_back({4'b0101, 32'h7F800000});
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      checks++;
      if (acc || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL b2b_stall_%0d: acc=%b ready=%b valid=%b data=%h, required 0 0 1 %h",
                 i, acc, in_ready, out_valid, out_data, held);
      end
    end
    out_ready = 1'b1;
    n = 0;
    do begin
      cycle(acc);
      n++;
    end while (!acc && n < 20);
    in_valid = 1'b0;
    drain();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: %0d results, required 4", obs_q.size());
    end
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_result_%0d: no result, required %h", n, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_result_%0d: got %h, required %h", n, o, e);
        end
      end
      n++;
    end
    obs_q.delete();
  endtask

  task automatic test_reset_inflight();
    bit acc;
    int lat;
    int bad;
    logic [35:0] e, o;
    out_ready = 1'b1;
    send(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
    send(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000});
    reset = 1'b1;
    cycle(acc);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b ready=%b, required 0 0", out_valid, in_ready);
    end
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(acc);
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_stale: %0d valid cycles, %0d results, required 0 0",
               bad, obs_q.size());
    end
    send(32'h3FC00001, 32'h3FC00001, {4'b0001, (Rne ? 32'h40100002 : 32'h40100001)});
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle(acc);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL midreset_latency: result after %0d cycles, required 3", lat);
    end
    drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL midreset_result: no result, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL midreset_result: got %h, required %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_extra: %0d unexpected results, required 0", obs_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_a      = '0;
    in_b      = '0;
    test_reset();
    test_basic();
    test_special();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (minimum 3).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (minimum 2); W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1.
REQ-003 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid  input  1, and in_ready  output  1: the operand handshake.
REQ-006 SHALL have ports in_a, in_b  input  W  IEEE-754-format operands {sign, exponent, fraction}.
REQ-007 SHALL have ports out_valid  output  1, and out_ready  input  1: the result handshake.
REQ-008 SHALL have port out_data  output  W  product.
REQ-009 SHALL have port out_flags  output  4  {invalid, overflow, underflow, inexact}, qualified by out_valid.

Function
REQ-010 SHALL transfer on a side only when valid and ready are both high at a rising edge.
REQ-011 SHALL be a 3-stage pipeline: S1 unpack/classify and (MAN_W+1)x(MAN_W+1) product; S2 normalise and exponent; S3 round, pack and flag registers.
REQ-012 SHALL present a result exactly 3 cycles after acceptance when out_ready is held high; throughput is 1 per cycle.
REQ-013 SHALL advance all stages together on adv = !out_valid || out_ready; in_ready = adv && !reset; bubbles are not collapsed.
REQ-014 SHALL hold out_data, out_flags and out_valid stable while out_valid && !out_ready; results leave in acceptance order with no loss or duplication.
REQ-015 SHALL compute sign = sign_a XOR sign_b for every result, NaN excepted.
REQ-016 SHALL treat exponent 0 operands (zero or subnormal) as signed zero (flush-to-zero).
REQ-017 SHALL output canonical qNaN {0, all-ones exponent, fraction MSB 1, rest 0} with invalid=1 when either input is NaN or for inf x zero.
REQ-018 SHALL output signed infinity, flags 0, for inf x finite nonzero; signed zero, flags 0, for zero x finite.
REQ-019 SHALL compute the exponent in EXP_W+2-bit signed arithmetic: E = Ea+Eb-BIAS, +1 when product MSB (bit 2*MAN_W+1) is set, with the mantissa shifted right by one.
REQ-020 SHALL derive guard = first dropped bit and sticky = OR of the remaining dropped bits; inexact = guard|sticky.
REQ-021 SHALL renormalise on a rounding carry-out: fraction 0, E+1.
REQ-022 SHALL, when final E >= 2^EXP_W-1, output signed infinity with overflow=1 and inexact=1.
REQ-023 SHALL, when final E <= 0, output signed zero with underflow=1 and inexact=1.

Reset
REQ-024 SHALL, while reset is high, clear all stage valid bits, out_valid=0, out_data=0, out_flags=0, in_ready=0.
REQ-025 SHALL discard in-flight operations when reset is asserted mid-operation; after release, out_valid stays 0 until new operands complete the pipeline.

Configuration
REQ-026 SHALL, with macro FPM_RNE_ROUND_EN defined, round to nearest, ties to even: increment when guard && (sticky || fraction LSB).
REQ-027 SHALL, without FPM_RNE_ROUND_EN, truncate (round toward zero); inexact is still reported and overflow saturates to infinity.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-028 SHALL test 0x3FC00000 x 0x40000000, out_ready=1 -> 0x40400000, flags 0000, exactly 3 cycles later.
REQ-029 SHALL test 0x7F800000 x 0x00000000 -> 0x7FC00000, flags 1000; 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0000.
REQ-030 SHALL test 0x7F000000 x 0x7F000000 -> 0x7F800000, flags 0101; 0x00800000 x 0x00800000 -> 0x00000000, flags 0011.
REQ-031 SHALL test 0x3FC00001 x 0x3FC00001 -> 0x40100002 with FPM_RNE_ROUND_EN, 0x40100001 without; flags 0001 in both builds.
REQ-032 SHALL test 4 back-to-back operands with out_ready=0 from the first out_valid for 5 cycles -> in_ready low, out_data stable, then all 4 results in order.
REQ-033 SHALL test reset pulsed with 2 operations in flight -> out_valid 0, no stale result; the next operand yields its correct result 3 cycles after acceptance.
